syscall_unit: RTL and testbench
===============================

// Module: syscall_unit
// PURPOSE
//  Services SPIM-style syscalls retired by the writeback stage. Takes the syscall flag, v0 and a0 that writeback produces.
//  Drives console output through valid/ready handshakes and walks data memory for string prints.
//  Holds the pipeline via stall_req while a service runs; raises a sticky halt on exit.
// PARAMETERS
//  MAX_STR_LEN  256  max chars emitted per print_string; reaching it terminates the string
//  ADDR_W       32   byte-address width of memory read port
// PORTS
//  clk          in   1       rising-edge clock
//  rst_n        in   1       async active-low reset
//  syscall_in   in   1       1-cycle pulse: syscall instruction retired in writeback
//  v0           in   32      service code, sampled with syscall_in
//  a0           in   32      argument, sampled with syscall_in
//  stall_req    out  1       to hazard unit: freeze pipeline while servicing
//  mem_rd_en    out  1       word read strobe to data memory
//  mem_rd_addr  out  ADDR_W  word-aligned read address ({addr[ADDR_W-1:2],2'b00})
//  mem_rd_data  in   32      read data, valid exactly 1 cycle after mem_rd_en
//  char_valid   out  1       console char available
//  char_data    out  8       console char
//  char_ready   in   1       console accepts char when char_valid & char_ready
//  int_valid    out  1       console integer available
//  int_data     out  32      signed integer to print
//  int_ready    in   1       console accepts int when int_valid & int_ready
//  halt         out  1       sticky: program exited (v0=10)
//  err_pulse    out  1       1-cycle: unsupported code, or syscall_in while busy
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE; all outputs 0; addr/count regs 0. Mid-service reset aborts with no further output.
//  States: IDLE, INT_OUT, CHAR_OUT, STR_REQ, STR_WAIT, STR_EMIT, HALTED.
//  IDLE: on syscall_in, latch v0/a0 and dispatch next cycle:
//   v0=1  -> INT_OUT;  v0=11 -> CHAR_OUT (char=a0[7:0]);  v0=4 -> STR_REQ (ptr=a0, count=0);
//   v0=10 -> HALTED;   other -> stay IDLE, err_pulse=1 next cycle.
//  INT_OUT: int_valid=1, int_data=latched a0, held stable until int_ready; handshake cycle -> IDLE.
//  CHAR_OUT: char_valid=1 held stable until char_ready; handshake -> IDLE.
//  STR_REQ: mem_rd_en=1 one cycle, addr=ptr word-aligned -> STR_WAIT.
//  STR_WAIT: capture mem_rd_data into word buffer -> STR_EMIT.
//  STR_EMIT: byte = buffer[8*ptr[1:0]+:8] (little-endian).
//   byte==0 -> IDLE, nothing emitted. count==MAX_STR_LEN -> IDLE, nothing emitted.
//   else char_valid=1; on handshake ptr+=1, count+=1; if new ptr[1:0]==0 -> STR_REQ, else stay STR_EMIT (reuse buffer).
//  HALTED: halt=1, terminal until reset; syscall_in ignored (no err).
//  stall_req: registered, =1 in every state except IDLE and HALTED; also 1 in the cycle after syscall_in is accepted.
//   Any syscall_in while stall_req=1 is dropped, err_pulse=1 next cycle.
//  HALTED stall_req=0, but hazard unit gates fetch on halt.
//  Unaligned a0 allowed: first read fetches containing word, emission starts at a0[1:0].
//  ptr wraps modulo 2^ADDR_W. count is ceil(log2(MAX_STR_LEN+1)) bits.
//  Latency: print_char with char_ready=1 -> char_valid 1 cycle after syscall_in, IDLE 2 cycles after.
// TESTING
//  1 print_int: syscall_in, v0=1, a0=32'hFFFF_FFF6, int_ready=1 -> int_data=-10 for one cycle, stall_req drops after handshake.
//  2 print_string: a0=0x100, mem[0x100]=0x6C6C6548, mem[0x104]=0x0000006F
//    -> chars 'H','e','l','l','o' in order, exactly 2 mem reads, then IDLE.
//  3 unaligned + backpressure: a0=0x102, char_ready toggled every 3 cycles
//    -> 'l','l','o' in order, char_data stable while char_valid & !char_ready.
//  4 MAX_STR_LEN=4, unterminated 8-byte string -> exactly 4 chars, then IDLE with err_pulse=0.
//  5 v0=10 -> halt=1 next cycle, stays 1; later syscall_in v0=1 -> no int_valid, no err_pulse.
//  6 v0=7 -> err_pulse single cycle; syscall_in during print_string -> err_pulse, string completes intact.
//    rst_n low mid-string -> all outputs 0 immediately.

Source files
------------

// File: rtl/syscall_unit.sv
// Syscall service unit: decodes SPIM-style syscalls retired by writeback and drives
// console int/char handshakes, walking data memory word by word for print_string.
module syscall_unit #(
    parameter int MAX_STR_LEN = 256,
    parameter int ADDR_W      = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              syscall_in,
    input  logic [31:0]       v0,
    input  logic [31:0]       a0,
    output logic              stall_req,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic [31:0]       mem_rd_data,
    output logic              char_valid,
    output logic [7:0]        char_data,
    input  logic              char_ready,
    output logic              int_valid,
    output logic [31:0]       int_data,
    input  logic              int_ready,
    output logic              halt,
    output logic              err_pulse
);

    localparam int CNT_W = $clog2(MAX_STR_LEN + 1);

    localparam logic [31:0] CODE_PRINT_INT  = 32'd1;
    localparam logic [31:0] CODE_PRINT_STR  = 32'd4;
    localparam logic [31:0] CODE_EXIT       = 32'd10;
    localparam logic [31:0] CODE_PRINT_CHAR = 32'd11;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_INT_OUT  = 3'd1,
        S_CHAR_OUT = 3'd2,
        S_STR_REQ  = 3'd3,
        S_STR_WAIT = 3'd4,
        S_STR_EMIT = 3'd5,
        S_HALTED   = 3'd6
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic [ADDR_W-1:0]   r_ptr;
    logic [ADDR_W-1:0]   w_ptr_nxt;
    logic [ADDR_W-1:0]   w_ptr_inc;
    logic [CNT_W-1:0]    r_count;
    logic [CNT_W-1:0]    w_count_nxt;
    logic [31:0]         r_buf;
    logic [31:0]         w_buf_nxt;
    logic [31:0]         w_emit_word;
    logic [7:0]          w_emit_byte;
    logic                w_code_ok;

    logic                r_stall;
    logic                r_mem_rd_en;
    logic [ADDR_W-1:0]   r_mem_rd_addr;
    logic                r_char_valid;
    logic [7:0]          r_char_data;
    logic                r_int_valid;
    logic [31:0]         r_int_data;
    logic                r_halt;
    logic                r_err;

    logic                w_stall_nxt;
    logic                w_mem_rd_en_nxt;
    logic [ADDR_W-1:0]   w_mem_rd_addr_nxt;
    logic                w_char_valid_nxt;
    logic [7:0]          w_char_data_nxt;
    logic                w_int_valid_nxt;
    logic [31:0]         w_int_data_nxt;
    logic                w_halt_nxt;
    logic                w_err_nxt;

    // Little-endian byte lane select within a fetched word.
    function automatic logic [7:0] sel_byte(input logic [31:0] word, input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            2'd3:    b = word[31:24];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    assign w_ptr_inc = r_ptr + ADDR_W'(1);
    assign w_code_ok = (v0 == CODE_PRINT_INT) || (v0 == CODE_PRINT_STR) ||
                       (v0 == CODE_EXIT)      || (v0 == CODE_PRINT_CHAR);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (syscall_in) begin
                    case (v0)
                        CODE_PRINT_INT:  w_next_state = S_INT_OUT;
                        CODE_PRINT_CHAR: w_next_state = S_CHAR_OUT;
                        CODE_PRINT_STR:  w_next_state = S_STR_REQ;
                        CODE_EXIT:       w_next_state = S_HALTED;
                        default:         w_next_state = S_IDLE;
                    endcase
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_INT_OUT: begin
                if (int_ready) w_next_state = S_IDLE;
                else           w_next_state = S_INT_OUT;
            end
            S_CHAR_OUT: begin
                if (char_ready) w_next_state = S_IDLE;
                else            w_next_state = S_CHAR_OUT;
            end
            S_STR_REQ:  w_next_state = S_STR_WAIT;
            S_STR_WAIT: w_next_state = S_STR_EMIT;
            S_STR_EMIT: begin
                // char_valid low here means the current byte was a terminator or the cap was hit
                if (!r_char_valid) begin
                    w_next_state = S_IDLE;
                end else if (char_ready) begin
                    w_next_state = (w_ptr_inc[1:0] == 2'b00) ? S_STR_REQ : S_STR_EMIT;
                end else begin
                    w_next_state = S_STR_EMIT;
                end
            end
            S_HALTED: w_next_state = S_HALTED;
            default:  w_next_state = S_IDLE;
        endcase
    end

    // Output and datapath lookahead: next values for every registered output.
    always_comb begin
        w_ptr_nxt         = r_ptr;
        w_count_nxt       = r_count;
        w_buf_nxt         = r_buf;
        w_emit_word       = r_buf;
        w_int_data_nxt    = r_int_data;
        w_char_data_nxt   = r_char_data;
        w_mem_rd_addr_nxt = r_mem_rd_addr;
        w_char_valid_nxt  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (syscall_in) begin
                    w_ptr_nxt       = a0[ADDR_W-1:0];
                    w_count_nxt     = '0;
                    w_int_data_nxt  = a0;
                    w_char_data_nxt = a0[7:0];
                end else begin
                    w_ptr_nxt = r_ptr;
                end
            end
            S_STR_WAIT: begin
                w_buf_nxt   = mem_rd_data;
                w_emit_word = mem_rd_data;
            end
            S_STR_EMIT: begin
                if (r_char_valid && char_ready) begin
                    w_ptr_nxt   = w_ptr_inc;
                    w_count_nxt = r_count + CNT_W'(1);
                end else begin
                    w_ptr_nxt = r_ptr;
                end
            end
            default: w_ptr_nxt = r_ptr;
        endcase

        w_emit_byte = sel_byte(w_emit_word, w_ptr_nxt[1:0]);
        case (w_next_state)
            S_CHAR_OUT: w_char_valid_nxt = 1'b1;
            S_STR_EMIT: begin
                w_char_valid_nxt = (w_emit_byte != 8'h00) && (w_count_nxt != CNT_W'(MAX_STR_LEN));
                if (w_char_valid_nxt) w_char_data_nxt = w_emit_byte;
                else                  w_char_data_nxt = r_char_data;
            end
            S_STR_REQ:  w_mem_rd_addr_nxt = {w_ptr_nxt[ADDR_W-1:2], 2'b00};
            default:    w_char_valid_nxt = 1'b0;
        endcase

        w_mem_rd_en_nxt = (w_next_state == S_STR_REQ);
        w_int_valid_nxt = (w_next_state == S_INT_OUT);
        w_halt_nxt      = (w_next_state == S_HALTED);
        w_stall_nxt     = (w_next_state != S_IDLE) && (w_next_state != S_HALTED);
        // r_stall mirrors "busy"; halted syscalls are silently ignored
        w_err_nxt       = syscall_in && (r_stall || ((r_state == S_IDLE) && !w_code_ok));
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr         <= '0;
            r_count       <= '0;
            r_buf         <= 32'h0;
            r_stall       <= 1'b0;
            r_mem_rd_en   <= 1'b0;
            r_mem_rd_addr <= '0;
            r_char_valid  <= 1'b0;
            r_char_data   <= 8'h00;
            r_int_valid   <= 1'b0;
            r_int_data    <= 32'h0;
            r_halt        <= 1'b0;
            r_err         <= 1'b0;
        end else begin
            r_ptr         <= w_ptr_nxt;
            r_count       <= w_count_nxt;
            r_buf         <= w_buf_nxt;
            r_stall       <= w_stall_nxt;
            r_mem_rd_en   <= w_mem_rd_en_nxt;
            r_mem_rd_addr <= w_mem_rd_addr_nxt;
            r_char_valid  <= w_char_valid_nxt;
            r_char_data   <= w_char_data_nxt;
            r_int_valid   <= w_int_valid_nxt;
            r_int_data    <= w_int_data_nxt;
            r_halt        <= w_halt_nxt;
            r_err         <= w_err_nxt;
        end
    end

    assign stall_req   = r_stall;
    assign mem_rd_en   = r_mem_rd_en;
    assign mem_rd_addr = r_mem_rd_addr;
    assign char_valid  = r_char_valid;
    assign char_data   = r_char_data;
    assign int_valid   = r_int_valid;
    assign int_data    = r_int_data;
    assign halt        = r_halt;
    assign err_pulse   = r_err;

endmodule

// File: tb/tb_syscall_unit.sv
// Bench for syscall_unit: directed scenarios plus randomized services checked against
// a console/memory reference model (byte-addressed string walk, expected output queues).
module tb_syscall_unit;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, syscall_in, syscall4_in, char_ready, int_ready;
    logic [31:0] v0, a0;
    logic        stall_req, mem_rd_en, char_valid, int_valid, halt, err_pulse;
    logic [31:0] mem_rd_addr, mem_rd_data, int_data;
    logic [7:0]  char_data;
    logic        stall4, mem4_rd_en, char4_valid, int4_valid, halt4, err4;
    logic [31:0] mem4_rd_addr, mem4_rd_data, int4_data;
    logic [7:0]  char4_data;

    logic [31:0] mem [0:255];

    syscall_unit #(.MAX_STR_LEN(256), .ADDR_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .syscall_in(syscall_in), .v0(v0), .a0(a0),
        .stall_req(stall_req), .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr),
        .mem_rd_data(mem_rd_data), .char_valid(char_valid), .char_data(char_data),
        .char_ready(char_ready), .int_valid(int_valid), .int_data(int_data),
        .int_ready(int_ready), .halt(halt), .err_pulse(err_pulse));

    syscall_unit #(.MAX_STR_LEN(4), .ADDR_W(32)) dut4 (
        .clk(clk), .rst_n(rst_n), .syscall_in(syscall4_in), .v0(v0), .a0(a0),
        .stall_req(stall4), .mem_rd_en(mem4_rd_en), .mem_rd_addr(mem4_rd_addr),
        .mem_rd_data(mem4_rd_data), .char_valid(char4_valid), .char_data(char4_data),
        .char_ready(char_ready), .int_valid(int4_valid), .int_data(int4_data),
        .int_ready(int_ready), .halt(halt4), .err_pulse(err4));

    // Data memory: one-cycle read latency for both read ports.
    always @(posedge clk) begin
        if (mem_rd_en)  mem_rd_data  <= mem[mem_rd_addr[9:2]];
        if (mem4_rd_en) mem4_rd_data <= mem[mem4_rd_addr[9:2]];
    end

    int          n_cmp = 0, n_bad = 0;
    int          cyc = 0, rdy_mode = 0, reads = 0, errs = 0, errs4 = 0;
    logic        hold_c = 1'b0, hold_i = 1'b0;
    logic [7:0]  held_c;
    logic [31:0] held_i;
    logic [7:0]  got_c[$], got_c4[$], exp_c[$];
    logic [31:0] got_i[$], got_i4[$], exp_i[$];
    int          injected = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] byte_at(input logic [31:0] x);
        logic [31:0] w;
        w = mem[x[9:2]];
        return w[8*x[1:0] +: 8];
    endfunction

    task automatic put_byte(input logic [31:0] x, input logic [7:0] b);
        mem[x[9:2]][8*x[1:0] +: 8] = b;
    endtask

    // Reference: console sees bytes from a onward until a NUL or maxlen chars.
    task automatic model_string(input logic [31:0] a, input int maxlen);
        logic [31:0] x;
        x = a;
        for (int n = 0; n < maxlen; n++) begin
            if (byte_at(x) == 8'h00) break;
            exp_c.push_back(byte_at(x));
            x = x + 32'd1;
        end
    endtask

    // One clock: pick readiness, observe handshakes at the falling edge, advance.
    task automatic cycle();
        case (rdy_mode)
            0:       begin char_ready = 1'b1; int_ready = 1'b1; end
            1:       begin char_ready = ((cyc / 3) % 2) == 1; int_ready = ((cyc / 3) % 2) == 1; end
            default: begin char_ready = 1'($urandom_range(0, 1)); int_ready = 1'($urandom_range(0, 1)); end
        endcase
        if (hold_c && rst_n) begin
            check_eq("char_hold_valid", char_valid, 1'b1);
            check_eq("char_hold_data", char_data, held_c);
        end
        if (hold_i && rst_n) begin
            check_eq("int_hold_valid", int_valid, 1'b1);
            check_eq("int_hold_data", int_data, held_i);
        end
        if (char_valid && char_ready)  got_c.push_back(char_data);
        if (char4_valid && char_ready) got_c4.push_back(char4_data);
        if (int_valid && int_ready)    got_i.push_back(int_data);
        if (int4_valid && int_ready)   got_i4.push_back(int4_data);
        if (mem_rd_en) begin
            reads++;
            check_eq("rd_addr_aligned", mem_rd_addr[1:0], 2'b00);
            check_eq("rd_addr_range", mem_rd_addr[31:10], 22'h0);
        end
        if (mem4_rd_en) check_eq("rd4_addr", {mem4_rd_addr[31:10], mem4_rd_addr[1:0]}, 24'h0);
        if (err_pulse) errs++;
        if (err4) errs4++;
        hold_c = char_valid && !char_ready;
        held_c = char_data;
        hold_i = int_valid && !int_ready;
        held_i = int_data;
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic issue(input logic [31:0] code, input logic [31:0] arg);
        v0 = code; a0 = arg; syscall_in = 1'b1;
        cycle();
        syscall_in = 1'b0;
    endtask

    // Run until both units are idle (bounded), optionally poking a syscall while busy.
    task automatic wait_idle(input logic inject, input int inj_at);
        int n;
        n = 0;
        injected = 0;
        while ((stall_req || stall4) && n < 2000) begin
            if (inject && n == inj_at && stall_req) begin
                syscall_in = 1'b1; v0 = 32'd1; a0 = $urandom;
                injected = 1;
            end
            cycle();
            syscall_in = 1'b0;
            n++;
        end
        check_eq("idle_within_budget", n < 2000, 1'b1);
        cycle();
    endtask

    task automatic compare_out(input string tag);
        check_eq({tag, "_nchars"}, got_c.size(), exp_c.size());
        for (int i = 0; i < exp_c.size() && i < got_c.size(); i++)
            check_eq({tag, "_char"}, got_c[i], exp_c[i]);
        check_eq({tag, "_nints"}, got_i.size(), exp_i.size());
        for (int i = 0; i < exp_i.size() && i < got_i.size(); i++)
            check_eq({tag, "_int"}, got_i[i], exp_i[i]);
    endtask

    task automatic clear_obs();
        got_c.delete(); got_c4.delete(); exp_c.delete();
        got_i.delete(); got_i4.delete(); exp_i.delete();
        reads = 0; errs = 0; errs4 = 0;
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_stall"}, stall_req, 1'b0);
        check_eq({tag, "_rd_en"}, mem_rd_en, 1'b0);
        check_eq({tag, "_rd_addr"}, mem_rd_addr, 32'h0);
        check_eq({tag, "_cvalid"}, char_valid, 1'b0);
        check_eq({tag, "_cdata"}, char_data, 8'h00);
        check_eq({tag, "_ivalid"}, int_valid, 1'b0);
        check_eq({tag, "_idata"}, int_data, 32'h0);
        check_eq({tag, "_halt"}, halt, 1'b0);
        check_eq({tag, "_err"}, err_pulse, 1'b0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] a, code;
        int          len, kind, exp_err;
        logic        inj;
        int          inj_at;

        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[32'h100 >> 2] = 32'h6C6C6548;
        mem[32'h104 >> 2] = 32'h0000006F;
        mem[32'h200 >> 2] = 32'h44434241;
        mem[32'h204 >> 2] = 32'h48474645;
        mem[32'h208 >> 2] = 32'h4C4B4A49;
        rst_n = 1'b0; syscall_in = 1'b0; syscall4_in = 1'b0;
        v0 = 32'h0; a0 = 32'h0; char_ready = 1'b0; int_ready = 1'b0;
        @(negedge clk);
        repeat (3) cycle();
        check_all_zero("reset");
        rst_n = 1'b1;
        cycle();

        // print_int of a negative value
        clear_obs(); rdy_mode = 0;
        issue(32'd1, 32'hFFFF_FFF6);
        check_eq("t1_ivalid", int_valid, 1'b1);
        check_eq("t1_idata", int_data, 32'hFFFF_FFF6);
        check_eq("t1_stall", stall_req, 1'b1);
        wait_idle(1'b0, 0);
        exp_i.push_back(32'hFFFF_FFF6);
        compare_out("t1");
        check_eq("t1_ivalid_after", int_valid, 1'b0);
        check_eq("t1_stall_after", stall_req, 1'b0);

        // print_char latency with console always ready
        clear_obs();
        issue(32'd11, 32'h0000_1241);
        check_eq("pc_cvalid", char_valid, 1'b1);
        check_eq("pc_cdata", char_data, 8'h41);
        cycle();
        check_eq("pc_idle_stall", stall_req, 1'b0);
        check_eq("pc_idle_cvalid", char_valid, 1'b0);

        // aligned "Hello"
        clear_obs();
        issue(32'd4, 32'h100);
        wait_idle(1'b0, 0);
        model_string(32'h100, 256);
        compare_out("t2");
        check_eq("t2_reads", reads, 2);
        check_eq("t2_stall", stall_req, 1'b0);

        // unaligned start, backpressure every 3 cycles
        clear_obs(); rdy_mode = 1;
        issue(32'd4, 32'h102);
        wait_idle(1'b0, 0);
        model_string(32'h102, 256);
        check_eq("t3_expected_len", exp_c.size(), 3);
        compare_out("t3");

        // 4-char cap on an unterminated string
        clear_obs(); rdy_mode = 0;
        v0 = 32'd4; a0 = 32'h200; syscall4_in = 1'b1;
        cycle();
        syscall4_in = 1'b0;
        wait_idle(1'b0, 0);
        model_string(32'h200, 4);
        check_eq("t4_nchars", got_c4.size(), 4);
        for (int i = 0; i < 4 && i < got_c4.size(); i++) check_eq("t4_char", got_c4[i], exp_c[i]);
        check_eq("t4_err", errs4, 0);
        check_eq("t4_halt", halt4, 1'b0);
        check_eq("t4_ints", got_i4.size(), 0);
        check_eq("t4_stall", stall4, 1'b0);

        // unsupported code, then syscall while a string is printing
        clear_obs();
        issue(32'd7, 32'h0);
        check_eq("t6_err_on", err_pulse, 1'b1);
        check_eq("t6_err_stall", stall_req, 1'b0);
        cycle();
        check_eq("t6_err_off", err_pulse, 1'b0);
        clear_obs(); rdy_mode = 1;
        issue(32'd4, 32'h100);
        wait_idle(1'b1, 2);
        model_string(32'h100, 256);
        compare_out("t6");
        check_eq("t6_injected", injected, 1);
        check_eq("t6_busy_err", errs, 1);

        // randomized services
        for (int t = 0; t < 40; t++) begin
            clear_obs();
            rdy_mode = $urandom_range(0, 2);
            kind     = $urandom_range(0, 3);
            inj      = ($urandom_range(0, 3) == 0);
            inj_at   = $urandom_range(0, 3);
            exp_err  = 0;
            case (kind)
                0: begin a = $urandom; exp_i.push_back(a); issue(32'd1, a); end
                1: begin a = $urandom; exp_c.push_back(a[7:0]); issue(32'd11, a); end
                2: begin
                    a   = 32'h300 + 32'($urandom_range(0, 63));
                    len = $urandom_range(0, 12);
                    for (int i = 0; i < len; i++) put_byte(a + 32'(i), 8'($urandom_range(1, 255)));
                    put_byte(a + 32'(len), 8'h00);
                    model_string(a, 256);
                    issue(32'd4, a);
                end
                default: begin
                    code = $urandom;
                    while (code == 32'd1 || code == 32'd4 || code == 32'd10 || code == 32'd11)
                        code = $urandom;
                    exp_err = 1;
                    issue(code, $urandom);
                end
            endcase
            wait_idle(inj, inj_at);
            compare_out("rnd");
            check_eq("rnd_errs", errs, exp_err + injected);
            check_eq("rnd_halt", halt, 1'b0);
        end

        // exit is sticky and silences further syscalls
        clear_obs(); rdy_mode = 0;
        issue(32'd10, 32'h0);
        check_eq("t5_halt", halt, 1'b1);
        check_eq("t5_stall", stall_req, 1'b0);
        repeat (3) begin
            cycle();
            check_eq("t5_halt_sticky", halt, 1'b1);
        end
        issue(32'd1, 32'h5);
        repeat (4) cycle();
        check_eq("t5_no_int", got_i.size(), 0);
        check_eq("t5_no_err", errs, 0);
        check_eq("t5_ivalid", int_valid, 1'b0);
        check_eq("t5_halt_end", halt, 1'b1);

        // reset clears halt, then reset mid-string aborts output
        rst_n = 1'b0;
        cycle();
        check_eq("rst_halt_clear", halt, 1'b0);
        rst_n = 1'b1;
        cycle();
        for (int i = 0; i < 20; i++) put_byte(32'h380 + 32'(i), 8'h61 + 8'(i));
        put_byte(32'h380 + 32'd20, 8'h00);
        clear_obs(); rdy_mode = 1;
        issue(32'd4, 32'h380);
        repeat (6) cycle();
        check_eq("mid_busy", stall_req, 1'b1);
        rst_n = 1'b0;
        #1;
        check_all_zero("midrst");
        got_c.delete();
        repeat (2) cycle();
        rst_n = 1'b1;
        repeat (5) cycle();
        check_eq("midrst_no_chars", got_c.size(), 0);
        check_eq("midrst_idle", stall_req, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
